// File: rtl/bcd_7seg_multi.sv
// rtl/bcd_7seg_multi.sv - multi-channel binary-to-BCD converter with multiplexed 7-segment scanner
// Values live in a small register file; one channel at a time is converted by a serial double-dabble engine.
module bcd_7seg_multi #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 16,
   parameter int DIGITS   = 5,
   parameter int SCAN_DIV = 1000
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic                                            en,
   input  logic                                            set_i,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_i,
   input  logic [DATA_W-1:0]                               data_i,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel_i,
   input  logic                                            get_i,
   input  logic                                            auto_i,
   output logic [4*DIGITS-1:0]                             bcd_o,
   output logic                                            valid_o,
   output logic                                            busy_o,
   output logic [6:0]                                      seg_o,
   output logic [DIGITS-1:0]                               an_o
);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   if (real'(DIGITS) * 3.321928094887362 <= real'(DATA_W)) begin : g_digits_check
      $fatal(1, "bcd_7seg_multi: DIGITS cannot hold every DATA_W value");
   end

   logic [DATA_W-1:0] regs [CHANNELS];
   logic              wr_ok;
   logic [CH_W-1:0]   sel_idx;

   assign wr_ok   = en & set_i & ({1'b0, ch_i} < CH_LIM);
   assign sel_idx = ({1'b0, sel_i} < CH_LIM) ? sel_i : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[ch_i] <= data_i;
      end
   end

   logic [0:0]        state;
   logic [DATA_W-1:0] snap;
   logic [BCD_W-1:0]  acc;
   logic [BCD_W-1:0]  adj;
   logic [BCD_W-1:0]  acc_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              pending;
   logic              start;
   logic              trig;
   logic [CH_W-1:0]   prev_sel;

   assign start  = (state == S_IDLE) & en & (get_i | pending);
   assign busy_o = (state == S_SHIFT);

   always_comb begin
      adj = acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc_nxt = BCD_W'({adj, snap[DATA_W-1]});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         snap    <= '0;
         acc     <= '0;
         cnt     <= '0;
         bcd_o   <= '0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_SHIFT;
                  snap  <= regs[sel_idx];
                  acc   <= '0;
                  cnt   <= CNT_W'(DATA_W);
               end
            end
            S_SHIFT: begin
               if (en) begin
                  acc  <= acc_nxt;
                  snap <= snap << 1;
                  cnt  <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     bcd_o   <= acc_nxt;
                     valid_o <= 1'b1;
                     state   <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Auto refresh: a write to the shown channel or a channel switch requests a new conversion.
   assign trig = (wr_ok & (ch_i == sel_i)) | (sel_i != prev_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= 1'b0;
         prev_sel <= '0;
      end else begin
         prev_sel <= sel_i;
         if (!auto_i)    pending <= 1'b0;
         else if (trig)  pending <= 1'b1;
         else if (start) pending <= 1'b0;
      end
   end

   logic [DIV_W-1:0] div;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] hi;
   logic [3:0]       digit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         idx <= '0;
      end else if (div == DIV_W'(SCAN_DIV - 1)) begin
         div <= '0;
         idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   assign an_o = DIGITS'(1) << idx;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // hi stays 0 for an all-zero value so the units digit always shows.
   always_comb begin
      hi = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_o[4*i +: 4] != 4'd0) hi = IDX_W'(i);
      end
      digit = bcd_o[{idx, 2'b00} +: 4];
      seg_o = (idx > hi) ? 7'h00 : seg_decode(digit);
   end

endmodule

// File: tb/tb_bcd_7seg_multi.sv
// tb/tb_bcd_7seg_multi.sv - scoreboard bench for bcd_7seg_multi
// Two instances: default-width (fast scan) and a 3-channel 10-bit variant.
module tb_bcd_7seg_multi;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        a_en, a_set, a_get, a_auto;
   logic [1:0]  a_ch, a_sel;
   logic [15:0] a_data;
   logic [19:0] a_bcd;
   logic        a_valid, a_busy;
   logic [6:0]  a_seg;
   logic [4:0]  a_an;

   logic        b_en, b_set, b_get, b_auto;
   logic [1:0]  b_ch, b_sel;
   logic [9:0]  b_data;
   logic [15:0] b_bcd;
   logic        b_valid, b_busy;
   logic [6:0]  b_seg;
   logic [3:0]  b_an;

   bcd_7seg_multi #(.CHANNELS(4), .DATA_W(16), .DIGITS(5), .SCAN_DIV(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(a_en), .set_i(a_set), .ch_i(a_ch), .data_i(a_data),
      .sel_i(a_sel), .get_i(a_get), .auto_i(a_auto), .bcd_o(a_bcd), .valid_o(a_valid),
      .busy_o(a_busy), .seg_o(a_seg), .an_o(a_an));

   bcd_7seg_multi #(.CHANNELS(3), .DATA_W(10), .DIGITS(4), .SCAN_DIV(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(b_en), .set_i(b_set), .ch_i(b_ch), .data_i(b_data),
      .sel_i(b_sel), .get_i(b_get), .auto_i(b_auto), .bcd_o(b_bcd), .valid_o(b_valid),
      .busy_o(b_busy), .seg_o(b_seg), .an_o(b_an));

   typedef struct {
      logic [19:0] bcd;
      int          at;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n && a_valid) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_valid got bcd=%h want=no_valid", a_bcd);
         end else begin
            e = qa.pop_front();
            chk("a_bcd", 32'(a_bcd), 32'(e.bcd));
            if (e.at >= 0) chk("a_latency", cyc, e.at);
            chk("a_busy_at_valid", 32'(a_busy), 32'd0);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst_n && b_valid) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_valid got bcd=%h want=no_valid", b_bcd);
         end else begin
            e = qb.pop_front();
            chk("b_bcd", 32'(b_bcd), 32'(e.bcd));
            if (e.at >= 0) chk("b_latency", cyc, e.at);
         end
      end
   end

   task automatic a_write(input logic [1:0] ch, input logic [15:0] d);
      @(negedge clk);
      a_set = 1'b1; a_ch = ch; a_data = d;
      @(negedge clk);
      a_set = 1'b0;
   endtask

   task automatic a_start(input logic [1:0] s, input logic [19:0] b, input int lat);
      @(negedge clk);
      a_sel = s; a_get = 1'b1;
      qa.push_back('{bcd: b, at: (lat < 0) ? -1 : cyc + 1 + lat});
      @(negedge clk);
      a_get = 1'b0;
   endtask

   task automatic a_wait(input string name);
      int n = 0;
      while ((qa.size() != 0 || a_busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done"}, 32'(n < 300), 32'd1);
      @(negedge clk);
   endtask

   task automatic a_frame(input logic [6:0] e0, e1, e2, e3, e4);
      logic [6:0] e [5];
      int cnt [5];
      int idx;
      e = '{e0, e1, e2, e3, e4};
      cnt = '{default: 0};
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("a_an_onehot", 32'($onehot(a_an)), 32'd1);
         idx = 0;
         for (int d = 0; d < 5; d++) if (a_an[d]) idx = d;
         cnt[idx]++;
         chk($sformatf("a_seg_d%0d", idx), 32'(a_seg), 32'(e[idx]));
      end
      for (int d = 0; d < 5; d++) chk($sformatf("a_dwell_d%0d", d), cnt[d], 32'd4);
   endtask

   task automatic b_write(input logic [1:0] ch, input logic [9:0] d);
      @(negedge clk);
      b_set = 1'b1; b_ch = ch; b_data = d;
      @(negedge clk);
      b_set = 1'b0;
   endtask

   task automatic b_start(input logic [1:0] s, input logic [15:0] b, input int lat);
      @(negedge clk);
      b_sel = s; b_get = 1'b1;
      qb.push_back('{bcd: {4'h0, b}, at: cyc + 1 + lat});
      @(negedge clk);
      b_get = 1'b0;
   endtask

   task automatic b_wait(input string name);
      int n = 0;
      while ((qb.size() != 0 || b_busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done"}, 32'(n < 200), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int n;
      a_en = 1'b1; a_set = 1'b0; a_get = 1'b0; a_auto = 1'b0;
      a_ch = '0; a_sel = '0; a_data = '0;
      b_en = 1'b1; b_set = 1'b0; b_get = 1'b0; b_auto = 1'b0;
      b_ch = '0; b_sel = '0; b_data = '0;

      repeat (3) @(negedge clk);
      chk("rst_bcd", 32'(a_bcd), 32'h0);
      chk("rst_valid", 32'(a_valid), 32'h0);
      chk("rst_busy", 32'(a_busy), 32'h0);
      chk("rst_an", 32'(a_an), 32'h1);
      chk("rst_seg", 32'(a_seg), 32'h3F);
      rst_n = 1'b1;

      // 0xFFFF: busy for 16 cycles, then 65535
      a_write(2'd2, 16'hFFFF);
      a_start(2'd2, 20'h65535, 16);
      n = 0;
      while (a_busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("a_busy_cycles", n, 32'd16);
      a_wait("t_ffff");

      a_write(2'd0, 16'd42);
      a_start(2'd0, 20'h00042, 16);
      a_wait("t_42");
      a_frame(7'h5B, 7'h66, 7'h00, 7'h00, 7'h00);

      a_start(2'd1, 20'h00000, 16);
      a_wait("t_zero");
      a_frame(7'h3F, 7'h00, 7'h00, 7'h00, 7'h00);

      // get and write to the converting channel while busy: snapshot wins
      a_write(2'd0, 16'd1234);
      a_start(2'd0, 20'h01234, 16);
      repeat (4) @(negedge clk);
      a_get = 1'b1; a_set = 1'b1; a_ch = 2'd0; a_data = 16'd999;
      @(negedge clk);
      a_get = 1'b0; a_set = 1'b0;
      a_wait("t_midwrite");
      a_start(2'd0, 20'h00999, 16);
      a_wait("t_999");

      a_start(2'd2, 20'h65535, 19);
      repeat (5) @(negedge clk);
      a_en = 1'b0;
      repeat (3) @(negedge clk);
      a_en = 1'b1;
      a_wait("t_en_stall");

      a_write(2'd3, 16'd100);
      @(negedge clk);
      a_sel = 2'd1; a_auto = 1'b1; a_set = 1'b1; a_ch = 2'd1; a_data = 16'd7;
      qa.push_back('{bcd: 20'h00007, at: cyc + 2 + 16});
      @(negedge clk);
      a_set = 1'b0;
      repeat (4) @(negedge clk);
      a_sel = 2'd3;
      qa.push_back('{bcd: 20'h00100, at: -1});
      a_wait("t_auto");
      a_auto = 1'b0;
      a_frame(7'h3F, 7'h3F, 7'h06, 7'h00, 7'h00);

      // reset in the middle of a conversion
      @(negedge clk);
      a_sel = 2'd2; a_get = 1'b1;
      @(negedge clk);
      a_get = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_bcd", 32'(a_bcd), 32'h0);
      chk("abort_valid", 32'(a_valid), 32'h0);
      chk("abort_busy", 32'(a_busy), 32'h0);
      chk("abort_an", 32'(a_an), 32'h1);
      chk("abort_seg", 32'(a_seg), 32'h3F);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      a_start(2'd2, 20'h00000, 16);
      a_wait("t_after_rst");
      chk("a_queue_empty", qa.size(), 32'd0);

      // small variant: out-of-range write ignored, out-of-range select maps to 0
      b_write(2'd0, 10'd5);
      b_write(2'd3, 10'd77);
      b_write(2'd2, 10'd1023);
      b_start(2'd2, 16'h1023, 10);
      b_wait("t_b_1023");
      b_start(2'd3, 16'h0005, 10);
      b_wait("t_b_sel3");
      chk("b_queue_empty", qb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
